// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared states, note codes and half-period table for the tone player
package note_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      GAP,
      DONE
   } state_t;

   localparam logic [3:0] NOTE_REST = 4'd0;
   localparam logic [3:0] NOTE_C4   = 4'd1;
   localparam logic [3:0] NOTE_D4   = 4'd2;
   localparam logic [3:0] NOTE_E4   = 4'd3;
   localparam logic [3:0] NOTE_F4   = 4'd4;
   localparam logic [3:0] NOTE_G4   = 4'd5;
   localparam logic [3:0] NOTE_A4   = 4'd6;
   localparam logic [3:0] NOTE_B4   = 4'd7;
   localparam logic [3:0] NOTE_C5   = 4'd8;

   localparam int HP_TABLE_W = 11;

   // Half period in microseconds; rest codes return 0 and are never toggled.
   function automatic logic [HP_TABLE_W-1:0] half_period(input logic [3:0] code);
      case (code)
         NOTE_C4: return 11'd1911;
         NOTE_D4: return 11'd1703;
         NOTE_E4: return 11'd1517;
         NOTE_F4: return 11'd1432;
         NOTE_G4: return 11'd1276;
         NOTE_A4: return 11'd1136;
         NOTE_B4: return 11'd1012;
         NOTE_C5: return 11'd956;
         default: return '0;
      endcase
   endfunction

   function automatic logic is_tone(input logic [3:0] code);
      return (code >= NOTE_C4) && (code <= NOTE_C5);
   endfunction

endpackage

// File: rtl/us_tick_gen.sv
// rtl/us_tick_gen.sv - synchronizes the 1 MHz divider output and emits one pulse per rising edge
module us_tick_gen (
   input  logic clk,
   input  logic rst,
   input  logic clk_1m_in,
   output logic us_tick
);

   logic sync1;
   logic sync2;
   logic dly;

   // Two flops for metastability, a delay flop for edge detect, registered tick pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         dly     <= 1'b0;
         us_tick <= 1'b0;
      end else begin
         sync1   <= clk_1m_in;
         sync2   <= sync1;
         dly     <= sync2;
         us_tick <= sync2 & ~dly;
      end
   end

endmodule

// File: rtl/note_tone_player.sv
// rtl/note_tone_player.sv - note request FSM and square-wave generator; NOTE_GAP_EN adds a silent gap after each note
module note_tone_player
   import note_pkg::*;
#(
   parameter int US_PER_MS = 1000,
   parameter int DUR_W     = 10,
   parameter int HP_W      = 11,
   parameter int GAP_MS    = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_1m_in,
   input  logic             note_valid,
   output logic             note_ready,
   input  logic [3:0]       note_code,
   input  logic [DUR_W-1:0] dur_ms,
   input  logic             abort,
   output logic             audio_out,
   output logic             busy,
   output logic             note_done
);

   localparam int US_W = $clog2(US_PER_MS);

   state_t           state;
   state_t           next_state;
   logic             us_tick;
   logic [US_W-1:0]  us_cnt;
   logic [DUR_W-1:0] ms_cnt;
   logic [DUR_W-1:0] ms_next;
   logic [DUR_W-1:0] dur_q;
   logic [HP_W-1:0]  half_cnt;
   logic [HP_W-1:0]  hp;
   logic [3:0]       code_q;
   logic             accept;
   logic             ms_wrap;
   logic             play_end;
   logic             gap_end;
   logic             tone;

   us_tick_gen u_tick (
      .clk       (clk),
      .rst       (rst),
      .clk_1m_in (clk_1m_in),
      .us_tick   (us_tick)
   );

   assign note_ready = (state == IDLE) && !abort;
   assign accept     = note_valid && note_ready;
   assign ms_next    = ms_cnt + 1'b1;
   assign ms_wrap    = us_tick && (us_cnt == US_W'(US_PER_MS - 1));
   // Equality compare only: the counter never runs past the target
   assign play_end   = ms_wrap && (ms_next == dur_q);
   assign gap_end    = ms_wrap && (ms_next == DUR_W'(GAP_MS));
   assign hp         = HP_W'(half_period(code_q));
   assign tone       = is_tone(code_q);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic and state-decoded status outputs
   always_comb begin
      next_state = state;
      busy       = (state != IDLE);
      note_done  = (state == DONE);
      if (abort) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: if (accept) next_state = (dur_ms == '0) ? DONE : PLAY;
            PLAY: if (play_end)
`ifdef NOTE_GAP_EN
               next_state = GAP;
`else
               next_state = DONE;
`endif
            GAP:  if (gap_end) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // Request latch, us/ms/half-period counters and the audio toggle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code_q    <= '0;
         dur_q     <= '0;
         us_cnt    <= '0;
         ms_cnt    <= '0;
         half_cnt  <= '0;
         audio_out <= 1'b0;
      end else if (abort) begin
         us_cnt    <= '0;
         ms_cnt    <= '0;
         half_cnt  <= '0;
         audio_out <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               code_q    <= note_code;
               dur_q     <= dur_ms;
               us_cnt    <= '0;
               ms_cnt    <= '0;
               half_cnt  <= '0;
               audio_out <= 1'b0;
            end
            PLAY, GAP: if (us_tick) begin
               if (ms_wrap) begin
                  us_cnt <= '0;
                  ms_cnt <= ms_next;
               end else begin
                  us_cnt <= us_cnt + 1'b1;
               end
               // End of a phase clears the counters so the gap reuses them from zero
               if ((state == PLAY && play_end) || (state == GAP && gap_end)) begin
                  us_cnt    <= '0;
                  ms_cnt    <= '0;
                  half_cnt  <= '0;
                  audio_out <= 1'b0;
               end else if (state == PLAY && tone) begin
                  if (half_cnt == hp - 1'b1) begin
                     audio_out <= ~audio_out;
                     half_cnt  <= '0;
                  end else begin
                     half_cnt <= half_cnt + 1'b1;
                  end
               end else begin
                  audio_out <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_note_tone_player.sv
// tb/tb_note_tone_player.sv - scoreboard bench for note_tone_player
module tb_note_tone_player;

   localparam int TPU = 4;
`ifdef NOTE_GAP_EN
   localparam int GAP_T = 20000;
`else
   localparam int GAP_T = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clk_1m_in = 1'b0;
   logic       note_valid = 1'b0;
   logic       note_ready;
   logic [3:0] note_code = 4'd0;
   logic [9:0] dur_ms = 10'd0;
   logic       abort = 1'b0;
   logic       audio_out;
   logic       busy;
   logic       note_done;

   typedef struct {
      int ticks;
      int rises;
      int hp;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   rises = 0;
   int   last_rise = -1;
   int   lat;
   int   div_cnt = 0;
   logic prev_audio = 1'b0;

   note_tone_player dut (
      .clk        (clk),
      .rst        (rst),
      .clk_1m_in  (clk_1m_in),
      .note_valid (note_valid),
      .note_ready (note_ready),
      .note_code  (note_code),
      .dur_ms     (dur_ms),
      .abort      (abort),
      .audio_out  (audio_out),
      .busy       (busy),
      .note_done  (note_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (div_cnt == 1) begin
         div_cnt   <= 0;
         clk_1m_in <= ~clk_1m_in;
      end else begin
         div_cnt <= div_cnt + 1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         prev_audio = 1'b0;
         rises      = 0;
         last_rise  = -1;
      end else begin
         if (audio_out && !prev_audio) begin
            rises++;
            if (last_rise >= 0 && sb.size() > 0)
               check("rise_interval", cyc - last_rise, 2 * sb[0].hp * TPU);
            last_rise = cyc;
         end
         prev_audio = audio_out;
         if (note_done) begin
            if (sb.size() == 0) begin
               check("spurious_done", 1, 0);
            end else begin
               e   = sb.pop_front();
               lat = cyc - acc_cyc;
               if (e.ticks == 0) check("done_latency", lat, 1);
               else check_range("done_latency", lat, e.ticks * TPU - 4, e.ticks * TPU + 1);
               check("rise_count", rises, e.rises);
               check("audio_at_done", int'(audio_out), 0);
            end
         end
         if (note_valid && note_ready) begin
            acc_cyc   = cyc;
            rises     = 0;
            last_rise = -1;
         end
      end
   end

   task automatic play(input logic [3:0] c, input int d, input int t, input int r,
                       input int h, input bit push);
      @(posedge clk); #2;
      note_valid = 1'b1;
      note_code  = c;
      dur_ms     = 10'(d);
      if (push) sb.push_back('{t, r, h});
      @(negedge clk);
      check("ready_at_issue", int'(note_ready), 1);
      @(posedge clk); #2;
      note_valid = 1'b0;
   endtask

   task automatic wait_empty(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         check("done_timeout", 0, 1);
         sb.delete();
      end
      repeat (3) @(negedge clk);
      check("idle_after_note", int'(busy), 0);
   endtask

   initial begin
      int bc;
      repeat (3) @(negedge clk);
      check("rst_audio", int'(audio_out), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(note_done), 0);
      check("rst_ready", int'(note_ready), 1);
      @(posedge clk); #2;
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Async reset in the middle of a note
      play(4'd6, 5, 0, 0, 1136, 1'b0);
      repeat (1500 * TPU) @(negedge clk);
      check("pre_rst_busy", int'(busy), 1);
      check("pre_rst_audio", int'(audio_out), 1);
      #2 rst = 1'b1;
      #1;
      check("midrst_audio", int'(audio_out), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(note_done), 0);
      check("midrst_ready", int'(note_ready), 1);
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", int'(note_ready), 1);
      check("post_rst_busy", int'(busy), 0);

      // A4 for 5 ms
      play(4'd6, 5, 5000 + GAP_T, 2, 1136, 1'b1);
      wait_empty((5000 + GAP_T) * TPU + 200);

      // Rest for 3 ms
      play(4'd0, 3, 3000 + GAP_T, 0, 0, 1'b1);
      wait_empty((3000 + GAP_T) * TPU + 200);

      // Zero duration
      play(4'd1, 0, 0, 0, 1911, 1'b1);
      bc = 0;
      repeat (4) begin
         @(negedge clk);
         if (busy) bc++;
      end
      check("dur0_busy_cycles", bc, 1);
      wait_empty(50);

      // Abort mid-note with a simultaneous request
      play(4'd8, 5, 0, 0, 956, 1'b0);
      repeat (2500 * TPU) @(negedge clk);
      @(posedge clk); #2;
      abort      = 1'b1;
      note_valid = 1'b1;
      note_code  = 4'd8;
      dur_ms     = 10'd1;
      sb.push_back('{1000 + GAP_T, 1, 956});
      @(negedge clk);
      check("abort_ready", int'(note_ready), 0);
      check("abort_busy_before", int'(busy), 1);
      @(posedge clk); #2;
      abort = 1'b0;
      @(negedge clk);
      check("abort_busy_after", int'(busy), 0);
      check("abort_audio", int'(audio_out), 0);
      check("abort_done", int'(note_done), 0);
      @(posedge clk); #2;
      note_valid = 1'b0;
      @(negedge clk);
      check("post_abort_accept", int'(busy), 1);
      wait_empty((1000 + GAP_T) * TPU + 200);

`ifdef NOTE_GAP_EN
      play(4'd3, 2, 22000, 1, 1517, 1'b1);
      repeat (5000 * TPU) @(negedge clk);
      check("gap_ready", int'(note_ready), 0);
      check("gap_audio", int'(audio_out), 0);
      check("gap_busy", int'(busy), 1);
      wait_empty(22000 * TPU + 200);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
